// File: rtl/m_encoder_pkg.sv
// Shared core package: instruction formats, decoded-instruction record, opcodes,
// and the RV32I field packer used by m_encoder.
package m_encoder_pkg;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } e_format;

  typedef struct packed {
    e_format     format;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;
  } s_decoded;

  localparam logic [6:0] OPC_OP     = 7'h33;
  localparam logic [6:0] OPC_OP_IMM = 7'h13;
  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_AUIPC  = 7'h17;
  localparam logic [6:0] OPC_JAL    = 7'h6F;
  localparam logic [6:0] OPC_JALR   = 7'h67;

  function automatic logic fmt_valid(input e_format f);
    return (f <= FMT_J);
  endfunction

  // Immediate bits outside each format's field are simply not selected.
  function automatic logic [31:0] pack_instr(input s_decoded d);
    logic [31:0] w;
    w = '0;
    case (d.format)
      FMT_R: w = {d.funct7, d.rs2, d.rs1, d.funct3, d.rd, d.opcode};
      FMT_I: w = {d.imm[11:0], d.rs1, d.funct3, d.rd, d.opcode};
      FMT_S: w = {d.imm[11:5], d.rs2, d.rs1, d.funct3, d.imm[4:0], d.opcode};
      FMT_B: w = {d.imm[12], d.imm[10:5], d.rs2, d.rs1, d.funct3,
                  d.imm[4:1], d.imm[11], d.opcode};
      FMT_U: w = {d.imm[31:12], d.rd, d.opcode};
      FMT_J: w = {d.imm[20], d.imm[10:1], d.imm[11], d.imm[19:12], d.rd, d.opcode};
      default: w = '0;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/m_encoder_imm_check.sv
// Immediate range/alignment check per instruction format.
// Compiled only when ENCODER_RANGE_CHECK_EN is defined.
`ifdef ENCODER_RANGE_CHECK_EN
module m_encoder_imm_check
  import m_encoder_pkg::*;
(
  input  e_format     format,
  input  logic [31:0] imm,
  output logic        ok
);

  always_comb begin
    ok = 1'b1;
    case (format)
      FMT_I, FMT_S: ok = (imm[31:11] == {21{imm[11]}});
      FMT_B:        ok = (imm[31:12] == {20{imm[12]}}) && !imm[0];
      FMT_U:        ok = (imm[11:0] == '0);
      FMT_J:        ok = (imm[31:20] == {12{imm[20]}}) && !imm[0];
      default:      ok = 1'b1;
    endcase
  end

endmodule
`endif

// File: rtl/m_encoder.sv
// Two-stage valid/ready RV32I instruction encoder (inverse of the decoder).
// Define ENCODER_RANGE_CHECK_EN to flag out-of-range or misaligned immediates.
module m_encoder
  import m_encoder_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  s_decoded    in_decoded,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic        out_err
);

  logic        s1_valid_q, s1_valid_d;
  s_decoded    s1_rec_q,   s1_rec_d;
  logic        s1_err_q,   s1_err_d;
  logic        s2_valid_q, s2_valid_d;
  logic [31:0] s2_instr_q, s2_instr_d;
  logic        s2_err_q,   s2_err_d;
  logic        s2_can_load;
  logic        range_ok;

`ifdef ENCODER_RANGE_CHECK_EN
  m_encoder_imm_check u_imm_check (
    .format (in_decoded.format),
    .imm    (in_decoded.imm),
    .ok     (range_ok)
  );
`else
  assign range_ok = 1'b1;
`endif

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_rec_d   = s1_rec_q;
    s1_err_d   = s1_err_q;
    s2_valid_d = s2_valid_q;
    s2_instr_d = s2_instr_q;
    s2_err_d   = s2_err_q;

    s2_can_load = !s2_valid_q || out_ready;
    in_ready    = !s1_valid_q || s2_can_load;

    // S1 reloads whenever it is free or draining this cycle; an empty load clears it.
    if (in_ready) begin
      s1_valid_d = in_valid;
      s1_rec_d   = in_decoded;
      s1_err_d   = !fmt_valid(in_decoded.format) || !range_ok;
    end

    if (s2_can_load) begin
      s2_valid_d = s1_valid_q;
      s2_err_d   = s1_valid_q && s1_err_q;
      s2_instr_d = (s1_valid_q && !s1_err_q) ? pack_instr(s1_rec_q) : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_rec_q   <= '0;
      s1_err_q   <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_instr_q <= '0;
      s2_err_q   <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_rec_q   <= s1_rec_d;
      s1_err_q   <= s1_err_d;
      s2_valid_q <= s2_valid_d;
      s2_instr_q <= s2_instr_d;
      s2_err_q   <= s2_err_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign out_instr = s2_instr_q;
  assign out_err   = s2_err_q;

endmodule
